// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   XLEN          : architectural register / address width
//   INST_NOP      : canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t : one queued fetch result, {pc, inst}
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous in-order FIFO with flush.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   flush      : drop all contents next edge (pointers and count to 0)
//   push       : write wdata at the tail; caller only pushes when there is room
//                or a pop happens in the same cycle
//   pop        : retire the head; caller only pops when count != 0
//   wdata      : entry to write
//   rdata      : head entry, read straight from registered storage
//   count      : current occupancy
// DEPTH need not be a power of two; pointers wrap explicitly.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the combinational-read
// imem, queues {pc, inst} pairs and hands them to decode.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   o_imem_addr       : fetch byte address (the PC register)
//   i_imem_data       : instruction word for o_imem_addr, same cycle
//   i_redirect_valid  : flush queue and restart fetch at i_redirect_pc
//   i_redirect_pc     : redirect target (low two bits ignored)
//   o_inst_valid      : queue head valid for decode
//   o_inst, o_inst_pc : queue head instruction and its PC
//   i_inst_ready      : decode accepts the head this cycle
//   o_count           : queue occupancy
module ifu_fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  localparam int         CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      o_imem_addr,
  input  logic [31:0]      i_imem_data,
  input  logic             i_redirect_valid,
  input  logic [31:0]      i_redirect_pc,
  output logic             o_inst_valid,
  output logic [31:0]      o_inst,
  output logic [31:0]      o_inst_pc,
  input  logic             i_inst_ready,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0]      pc;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  fetch_entry_t     wr_entry;
  fetch_entry_t     rd_entry;

  // Valid is masked during a redirect so decode never consumes a stale entry
  // in the cycle the queue is being thrown away.
  assign o_inst_valid = (count != '0) && !i_redirect_valid;
  assign pop          = o_inst_valid && i_inst_ready;
  // A full queue can still accept a fetch when the head leaves the same cycle.
  assign push         = !i_redirect_valid && ((count < CNT_W'(DEPTH)) || pop);

  assign wr_entry.pc   = pc;
  assign wr_entry.inst = i_imem_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC & PC_ALIGN_MASK;
    end else if (i_redirect_valid) begin
      pc <= i_redirect_pc & PC_ALIGN_MASK;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  sync_fifo #(
    .DATA_W ($bits(fetch_entry_t)),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (i_redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count)
  );

  assign o_imem_addr = pc;
  assign o_inst      = rd_entry.inst;
  assign o_inst_pc   = rd_entry.pc;
  assign o_count     = count;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed scenarios followed by a randomized run,
// all checked against a queue-based reference model.
module tb_ifu_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic [31:0]      o_imem_addr;
  logic [31:0]      i_imem_data;
  logic             i_redirect_valid;
  logic [31:0]      i_redirect_pc;
  logic             o_inst_valid;
  logic [31:0]      o_inst;
  logic [31:0]      o_inst_pc;
  logic             i_inst_ready;
  logic [CNT_W-1:0] o_count;

  int          checks;
  int          errors;
  bit          nop_mode;
  logic [63:0] q[$];
  logic [31:0] mpc;

  ifu_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_addr      (o_imem_addr),
    .i_imem_data      (i_imem_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready),
    .o_count          (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_of(input logic [31:0] a, input bit nop);
    if (nop) return INST_NOP;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign i_imem_data = imem_of(o_imem_addr, nop_mode);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc = RESET_PC & 32'hFFFF_FFFC;
  endtask

  // Called at a falling edge: apply inputs, check outputs, advance the model
  // by one clock, return at the next falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          ev;
    bit          do_pop;
    bit          do_push;
    logic [63:0] e;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    i_inst_ready     = rdy;
    #1;
    ev = (q.size() != 0) && !redir;
    check("imem_addr", o_imem_addr, mpc);
    check("count", 32'(o_count), q.size());
    check("valid", {31'b0, o_inst_valid}, {31'b0, ev});
    if (ev) begin
      e = q[0];
      check("inst_pc", o_inst_pc, e[63:32]);
      check("inst", o_inst, e[31:0]);
    end
    if (redir) begin
      q.delete();
      mpc = rpc & 32'hFFFF_FFFC;
    end else begin
      do_pop  = ev && rdy;
      do_push = (q.size() < DEPTH) || do_pop;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back({mpc, imem_of(mpc, nop_mode)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted away from any clock edge; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr", o_imem_addr, RESET_PC & 32'hFFFF_FFFC);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_valid", {31'b0, o_inst_valid}, 32'd0);
    check("rst_inst", o_inst, 32'd0);
    check("rst_inst_pc", o_inst_pc, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    nop_mode         = 1'b1;
    rst_n            = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_inst_ready     = 1'b0;
    model_reset();

    // Streaming NOPs with decode always ready.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Decode stall fills the queue, then drain with push+pop while full.
    nop_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
    check("sat_count", 32'(o_count), 32'd4);
    check("stall_addr", o_imem_addr, 32'h10);
    check("stall_head_pc", o_inst_pc, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect to an unaligned target while three entries are queued.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    check("pre_redir_count", 32'(o_count), 32'd3);
    step(1'b1, 32'h0000_0103, 1'b1);
    check("post_redir_count", 32'(o_count), 32'd0);
    check("post_redir_addr", o_imem_addr, 32'h100);
    step(1'b0, 32'h0, 1'b1);
    check("redir_head_pc", o_inst_pc, 32'h100);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

    // PC wrap through the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

    // Reset mid-stream with two entries queued.
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b0);
    check("mid_count", 32'(o_count), 32'd2);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    // Randomized redirects and decode back-pressure.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      bit          rd;
      bit          rdy;
      rd  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      step(rd, tgt, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
